sample_playback_engine: RTL and testbench

SAMPLE_PLAYBACK_ENGINE -- requirements
Module: sample_playback_engine

---
 rtl/sample_pkg.sv | 17 +
 rtl/sample_envelope.sv | 102 ++++++++++
 rtl/sample_playback_engine.sv | 103 ++++++++++
 tb/tb_sample_playback_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and constants for the sample playback engine.
//   env_state_t : envelope FSM state encoding
//   GAIN_WIDTH  : width of the unsigned gain word (0..GAIN_MAX)
//   GAIN_MAX    : unity gain
package sample_pkg;

    localparam int GAIN_WIDTH = 9;
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = GAIN_WIDTH'(256);

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/sample_envelope.sv
// Envelope FSM and gain register.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   tick_i         : one-cycle pulse per audio sample period
//   gate_i         : note-on level
//   state_next_o   : state that takes effect at the coming edge
//   gain_next_o    : gain that takes effect at the coming edge
//   active_o       : registered state is not IDLE
//
// state   | meaning
// IDLE    | silent, gain held at 0
// ATTACK  | gain ramps up by RAMP_STEP per tick until GAIN_MAX
// SUSTAIN | gain held at GAIN_MAX while the gate is high
// RELEASE | gain ramps down by RAMP_STEP per tick until 0
module sample_envelope
    import sample_pkg::*;
#(
    parameter int RAMP_STEP = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  tick_i,
    input  logic                  gate_i,
    output env_state_t            state_next_o,
    output logic [GAIN_WIDTH-1:0] gain_next_o,
    output logic                  active_o
);

    localparam logic [GAIN_WIDTH:0] STEP     = (GAIN_WIDTH+1)'(RAMP_STEP);
    localparam logic [GAIN_WIDTH:0] GAIN_TOP = {1'b0, GAIN_MAX};

    env_state_t            state_q, state_d;
    logic [GAIN_WIDTH-1:0] gain_q, gain_d;
    logic                  gate_prev_q;
    logic                  gate_rise, gate_fall;
    logic [GAIN_WIDTH:0]   gain_up, gain_dn;

    assign gate_rise = gate_i & ~gate_prev_q;
    assign gate_fall = ~gate_i & gate_prev_q;
    assign gain_up   = {1'b0, gain_q} + STEP;
    assign gain_dn   = {1'b0, gain_q} - STEP;

    // A gate edge wins over a tick in the same cycle: the gain is left alone.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            ENV_IDLE: begin
                gain_d = '0;
                if (gate_rise) state_d = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (gate_fall) begin
                    state_d = ENV_RELEASE;
                end else if (tick_i) begin
                    if (gain_up >= GAIN_TOP) begin
                        gain_d  = GAIN_MAX;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        gain_d = gain_up[GAIN_WIDTH-1:0];
                    end
                end
            end
            ENV_SUSTAIN: begin
                gain_d = GAIN_MAX;
                if (gate_fall) state_d = ENV_RELEASE;
            end
            ENV_RELEASE: begin
                if (gate_rise) begin
                    state_d = ENV_ATTACK;
                end else if (tick_i) begin
                    if ({1'b0, gain_q} <= STEP) begin
                        gain_d  = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        gain_d = gain_dn[GAIN_WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = ENV_IDLE;
                gain_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ENV_IDLE;
            gain_q      <= '0;
            gate_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            gate_prev_q <= gate_i;
        end
    end

    assign state_next_o = state_d;
    assign gain_next_o  = gain_d;
    assign active_o     = (state_q != ENV_IDLE);

endmodule

// File: rtl/sample_playback_engine.sv
// Sample playback engine: reads signed samples from an external BRAM and
// scales them by an attack/sustain/release envelope gain.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   sample_tick    : one-cycle pulse per audio sample period
//   gate_in        : note-on level
//   sample_addr    : upstream address counter
//   bram_addr      : BRAM read address (output)
//   bram_dout      : signed BRAM read data, BRAM_LATENCY cycles after address
//   sample_out     : gain-scaled sample, held between valid pulses
//   sample_valid   : one-cycle pulse BRAM_LATENCY+2 cycles after each tick
//   active         : envelope is not IDLE
module sample_playback_engine
    import sample_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int BRAM_DEPTH   = 8192,
    parameter int DATA_WIDTH   = 16,
    parameter int BRAM_LATENCY = 2,
    parameter int RAMP_STEP    = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_tick,
    input  logic                  gate_in,
    input  logic [ADDR_WIDTH-1:0] sample_addr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  active
);

    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BRAM_DEPTH - 1);

    env_state_t            env_state_next;
    logic [GAIN_WIDTH-1:0] env_gain_next;

    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [BRAM_LATENCY:0] valid_pipe_q;
    logic [GAIN_WIDTH-1:0] gain_pipe_q [BRAM_LATENCY+1];
    logic [DATA_WIDTH-1:0] sample_out_q, sample_d;
    logic                  sample_valid_q;
    logic signed [PROD_W-1:0] product;

    sample_envelope #(
        .RAMP_STEP (RAMP_STEP)
    ) u_envelope (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .tick_i       (sample_tick),
        .gate_i       (gate_in),
        .state_next_o (env_state_next),
        .gain_next_o  (env_gain_next),
        .active_o     (active)
    );

    // The address rule follows the state being entered, so a gate edge
    // coinciding with a tick already reads with the new rule. In release the
    // upstream counter is parked at 0, so we free-run our own address.
    always_comb begin
        bram_addr_d = bram_addr_q;
        if (sample_tick) begin
            if (env_state_next == ENV_RELEASE) begin
                bram_addr_d = (bram_addr_q == ADDR_LAST) ? '0
                                                         : bram_addr_q + ADDR_WIDTH'(1);
            end else begin
                bram_addr_d = sample_addr;
            end
        end
    end

    // Gain in effect at the tick travels alongside the read so it meets the
    // matching BRAM word.
    assign product  = PROD_W'($signed(bram_dout))
                    * PROD_W'($signed({1'b0, gain_pipe_q[BRAM_LATENCY]}));
    assign sample_d = DATA_WIDTH'(product >>> 8);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bram_addr_q    <= '0;
            valid_pipe_q   <= '0;
            for (int i = 0; i <= BRAM_LATENCY; i++) gain_pipe_q[i] <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            bram_addr_q     <= bram_addr_d;
            valid_pipe_q[0] <= sample_tick;
            gain_pipe_q[0]  <= env_gain_next;
            for (int i = 1; i <= BRAM_LATENCY; i++) begin
                valid_pipe_q[i] <= valid_pipe_q[i-1];
                gain_pipe_q[i]  <= gain_pipe_q[i-1];
            end
            sample_valid_q <= valid_pipe_q[BRAM_LATENCY];
            if (valid_pipe_q[BRAM_LATENCY]) sample_out_q <= sample_d;
        end
    end

    assign bram_addr    = bram_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sample_playback_engine.sv
module tb_sample_playback_engine;

    localparam int AW    = 13;
    localparam int DEPTH = 8192;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int STEP  = 32;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          sample_tick = 1'b0;
    logic          gate_in = 1'b0;
    logic [AW-1:0] sample_addr = '0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          active;

    sample_playback_engine #(
        .ADDR_WIDTH   (AW),
        .BRAM_DEPTH   (DEPTH),
        .DATA_WIDTH   (DW),
        .BRAM_LATENCY (LAT),
        .RAMP_STEP    (STEP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_tick  (sample_tick),
        .gate_in      (gate_in),
        .sample_addr  (sample_addr),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active       (active)
    );

    always #5 clk_in = ~clk_in;

    // BRAM: two-cycle read latency from address change
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_stage;
    always @(posedge clk_in) begin
        rd_stage  <= mem[bram_addr];
        bram_dout <= rd_stage;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ATTACK, M_SUSTAIN, M_RELEASE} mst_t;
    typedef struct {int due; logic [DW-1:0] val;} pend_t;

    mst_t          m_st = M_IDLE;
    int            m_gain = 0;
    bit            m_gate_d = 0;
    int            m_addr = 0;
    int            mcyc = 0;
    pend_t         pend_q[$];
    logic [DW-1:0] m_out = '0;
    bit            m_rise, m_fall, exp_v;

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] d, input int g);
        int p;
        p = int'($signed(d)) * g;
        return DW'(p >>> 8);
    endfunction

    always @(posedge clk_in) begin
        mcyc++;
        if (rst_in) begin
            m_st = M_IDLE; m_gain = 0; m_gate_d = 0; m_addr = 0; m_out = '0;
            pend_q.delete();
        end else begin
            m_rise = gate_in && !m_gate_d;
            m_fall = !gate_in && m_gate_d;
            if (m_rise && (m_st == M_IDLE || m_st == M_RELEASE)) m_st = M_ATTACK;
            else if (m_fall && (m_st == M_ATTACK || m_st == M_SUSTAIN)) m_st = M_RELEASE;
            else if (sample_tick && m_st == M_ATTACK) begin
                m_gain = (m_gain + STEP >= 256) ? 256 : m_gain + STEP;
                if (m_gain == 256) m_st = M_SUSTAIN;
            end else if (sample_tick && m_st == M_RELEASE) begin
                m_gain = (m_gain <= STEP) ? 0 : m_gain - STEP;
                if (m_gain == 0) m_st = M_IDLE;
            end
            if (sample_tick) begin
                m_addr = (m_st == M_RELEASE) ? (m_addr + 1) % DEPTH : int'(sample_addr);
                pend_q.push_back('{mcyc + LAT + 1, scale(mem[m_addr], m_gain)});
            end
            m_gate_d = gate_in;
        end
    end

    always @(posedge clk_in) begin
        #4;
        exp_v = 0;
        if (pend_q.size() > 0 && pend_q[0].due == mcyc) begin
            exp_v = 1;
            m_out = pend_q[0].val;
            void'(pend_q.pop_front());
        end
        chk("model{valid,active,addr,out}",
            {sample_valid, active, bram_addr, sample_out},
            {exp_v, (m_st != M_IDLE), AW'(m_addr), m_out});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        gate_in = 0; sample_tick = 0; sample_addr = '0;
        rst_in = 1; cyc(2);
        rst_in = 0; cyc(1);
    endtask

    task automatic tick_once();
        sample_tick = 1; cyc(1); sample_tick = 0;
    endtask

    task automatic ramp_to_sustain(input logic [AW-1:0] a);
        gate_in = 1; sample_addr = a; cyc(1);
        repeat (8) begin tick_once(); cyc(3); end
    endtask

    typedef struct {logic [DW-1:0] dout; int nticks; logic [DW-1:0] res;} vec_t;
    vec_t tbl[11];

    logic [9:0] vm;
    bit         any_v;

    initial begin
        tbl[0]  = '{16'h4000, 1,  16'h0800};
        tbl[1]  = '{16'h4000, 8,  16'h4000};
        tbl[2]  = '{16'h8000, 8,  16'h8000};
        tbl[3]  = '{16'h8000, 4,  16'hC000};
        tbl[4]  = '{16'h7FFF, 4,  16'h3FFF};
        tbl[5]  = '{16'hFFFF, 1,  16'hFFFF};
        tbl[6]  = '{16'h0100, 3,  16'h0060};
        tbl[7]  = '{16'hC000, 2,  16'hF000};
        tbl[8]  = '{16'h1234, 10, 16'h1234};
        tbl[9]  = '{16'h7FFF, 8,  16'h7FFF};
        tbl[10] = '{16'h8001, 1,  16'hF000};
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        cyc(1);
        chk("reset_outputs", {sample_out, bram_addr, sample_valid, active}, 0);
        rst_in = 0; cyc(1);

        // gain table: attack ticks then scaled output
        for (int i = 0; i < 11; i++) begin
            do_reset();
            mem[5] = tbl[i].dout;
            gate_in = 1; sample_addr = 13'd5; cyc(1);
            for (int t = 0; t < tbl[i].nticks; t++) begin tick_once(); cyc(3); end
            cyc(5);
            chk($sformatf("table%0d", i), sample_out, tbl[i].res);
        end

        // tick-to-valid latency, in IDLE
        do_reset();
        mem[0] = 16'h1111;
        tick_once();
        vm = '0;
        vm[1] = sample_valid;
        for (int j = 2; j <= 7; j++) begin cyc(1); vm[j] = sample_valid; end
        chk("latency_T+4", vm, 10'b00_0001_0000);
        chk("idle_out_zero", sample_out, 0);

        // back-to-back ticks
        do_reset();
        sample_tick = 1; cyc(3); sample_tick = 0;
        vm = '0;
        for (int j = 3; j <= 9; j++) begin vm[j] = sample_valid; cyc(1); end
        chk("back_to_back", vm, 10'h070);

        // release addressing and wrap, then IDLE
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100;
        ramp_to_sustain(13'h1FFE);
        chk("sustain_addr", bram_addr, 13'h1FFE);
        chk("sustain_out", sample_out, 16'h0100);
        gate_in = 0; sample_addr = '0; cyc(1);
        tick_once(); chk("rel_addr_1FFF", bram_addr, 13'h1FFF); cyc(3);
        tick_once(); chk("rel_addr_0000", bram_addr, 13'h0000); cyc(3);
        tick_once(); chk("rel_addr_0001", bram_addr, 13'h0001); cyc(3);
        repeat (4) begin tick_once(); cyc(3); end
        chk("rel_active_7", active, 1);
        chk("rel_out_32", sample_out, 16'h0020);
        tick_once();
        chk("rel_idle_active", active, 0);
        cyc(3);
        chk("rel_idle_out", sample_out, 0);

        // re-rise during release at gain 96, with a coincident tick
        do_reset();
        ramp_to_sustain(13'h0100);
        gate_in = 0; sample_addr = '0; cyc(1);
        repeat (5) begin tick_once(); cyc(3); end
        chk("rel_gain96", sample_out, 16'h0060);
        gate_in = 1; sample_addr = 13'h0010;
        tick_once();
        chk("rerise_addr", bram_addr, 13'h0010);
        chk("rerise_active", active, 1);
        cyc(3);
        chk("rerise_hold96", sample_out, 16'h0060);
        tick_once(); cyc(3); chk("rerise_128", sample_out, 16'h0080);
        tick_once(); cyc(3); chk("rerise_160", sample_out, 16'h00A0);

        // reset two cycles after a tick discards in-flight samples
        do_reset();
        gate_in = 1; sample_addr = 13'd5; cyc(1);
        tick_once(); tick_once(); cyc(1);
        rst_in = 1; gate_in = 0; sample_addr = '0;
        any_v = 0;
        cyc(1);
        rst_in = 0;
        for (int j = 0; j < 8; j++) begin any_v |= sample_valid; cyc(1); end
        chk("rst_no_valid", any_v, 0);
        chk("rst_outputs", {sample_out, bram_addr, active}, 0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_in = 1; sample_tick = 0; cyc(2); rst_in = 0;
            end
            if ($urandom_range(0, 39) == 0) gate_in = ~gate_in;
            sample_tick = ($urandom_range(0, 2) == 0);
            sample_addr = gate_in ? AW'($urandom) : '0;
            cyc(1);
        end
        sample_tick = 0;
        cyc(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
